multi_cycle_adder: RTL and testbench

Parametrised, multi-cycle successor to the single-bit full adder. It adds two WIDTH-bit operands plus a carry-in by processing SLICE bits per clock, LSB slice first, through a SLICE-bit ripple chain of full-adder cells. It exposes a start/ready/done handshake so datapath controllers can trade adder area for latency. Outputs are carry-out and signed overflow.

---
 rtl/multi_cycle_adder.sv | 144 ++++++++++++++
 tb/tb_multi_cycle_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: adds two WIDTH-bit operands plus carry-in over K = WIDTH/SLICE
// cycles, SLICE bits per cycle (LSB slice first) through a SLICE-bit ripple chain.
// WIDTH >= 1, SLICE >= 1, SLICE must divide WIDTH.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request an add; accepted when ready=1
//   a, b       operands, sampled on the accepting edge
//   c_in       carry into bit 0, sampled on the accepting edge
//   ready      high in IDLE and DONE
//   done       one-cycle pulse when results are valid
//   sum        (a + b + c_in) mod 2^WIDTH
//   carry_out  carry out of bit WIDTH-1
//   overflow   carry into MSB xor carry out of MSB
module multi_cycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned K  = WIDTH / SLICE;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             chain_c, chain_c_msb;

  // Slice select, ripple chain and partial-sum merge
  always_comb begin
    slice_a     = '0;
    slice_b     = '0;
    slice_sum   = '0;
    chain_c     = carry;
    chain_c_msb = carry;
    acc_next    = acc;
    for (int unsigned k = 0; k < K; k++) begin
      if (cnt == CW'(k)) begin
        slice_a = a_reg[k*SLICE +: SLICE];
        slice_b = b_reg[k*SLICE +: SLICE];
      end
    end
    for (int unsigned i = 0; i < SLICE; i++) begin
      // carry into the top bit of the slice; on the last slice this is the carry into the MSB
      chain_c_msb  = chain_c;
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ chain_c;
      chain_c      = (slice_a[i] & slice_b[i]) | (chain_c & (slice_a[i] ^ slice_b[i]));
    end
    for (int unsigned k = 0; k < K; k++) begin
      if (cnt == CW'(k)) begin
        acc_next[k*SLICE +: SLICE] = slice_sum;
      end
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (cnt == CW'(K - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, operand/partial registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      acc       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next != RUN);
      done  <= (state_next == DONE);
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        carry <= c_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        carry <= chain_c;
        cnt   <= cnt + CW'(1);
        acc   <= acc_next;
        // results become visible only when the final slice lands
        if (last) begin
          sum       <= acc_next;
          carry_out <= chain_c;
          overflow  <= chain_c_msb ^ chain_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed self-checking bench for multi_cycle_adder: 16/4 instance for handshake,
// reset and back-to-back behaviour; 4/1 and 4/4 instances swept exhaustively.
module tb_multi_cycle_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit, 4-bit slice instance
  logic        start16, c16, rdy16, d16, co16, ov16;
  logic [15:0] a16, b16, s16;

  // 4-bit sweep instances share inputs
  logic       st4, c4;
  logic [3:0] a4, b4;
  logic       rdy41, d41, co41, ov41, rdy44, d44, co44, ov44;
  logic [3:0] s41, s44;

  multi_cycle_adder #(.WIDTH(16), .SLICE(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .c_in(c16),
    .ready(rdy16), .done(d16), .sum(s16), .carry_out(co16), .overflow(ov16));

  multi_cycle_adder #(.WIDTH(4), .SLICE(1)) u41 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .c_in(c4),
    .ready(rdy41), .done(d41), .sum(s41), .carry_out(co41), .overflow(ov41));

  multi_cycle_adder #(.WIDTH(4), .SLICE(4)) u44 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .c_in(c4),
    .ready(rdy44), .done(d44), .sum(s44), .carry_out(co44), .overflow(ov44));

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One add on the 16-bit instance from IDLE; optionally pokes start and new operands mid-RUN
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, input logic [15:0] es, input logic ec, input logic ev,
                       input logic [15:0] prev, input bit poke);
    int lat;
    int extra;
    bit got;
    a16 = ta; b16 = tb; c16 = tc; start16 = 1'b1;
    step();
    start16 = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      step();
      lat++;
      if (d16) got = 1'b1;
      else if (lat == 2) begin
        chk({tag, "_hold"}, {rdy16, s16}, {1'b0, prev});
        if (poke) begin
          start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
        end
      end else if (lat == 3) begin
        start16 = 1'b0;
      end
    end
    chk({tag, "_res"}, {8'(lat), rdy16, ov16, co16, s16}, {8'd4, 1'b1, ev, ec, es});
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d16) extra++;
    end
    chk({tag, "_nodone"}, {rdy16, 32'(extra)}, {1'b1, 32'd0});
  endtask

  initial begin
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic [15:0] ps [3];
    logic        pc [3];
    logic        pco [3];
    logic        pov [3];
    int k;
    int extra;

    rst_n = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    st4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    step();
    step();
    chk("reset", {rdy16, d16, co16, ov16, s16}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;
    step();

    run16("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    run16("posov",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b0);
    run16("negov",  16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b0);
    run16("ignore", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 16'h0001, 1'b1);

    // Reset on the second RUN edge aborts the add
    a16 = 16'h0F0F; b16 = 16'h0101; c16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    rst_n = 1'b0; start16 = 1'b1;
    step();
    chk("midrst", {rdy16, d16, co16, ov16, s16}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    step();
    rst_n = 1'b1; start16 = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d16) extra++;
    end
    chk("midrst_nodone", {rdy16, 32'(extra)}, {1'b1, 32'd0});
    run16("afterrst", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Back-to-back with start held high
    pa[0] = 16'h1111; pb[0] = 16'h2222; pc[0] = 1'b0; ps[0] = 16'h3333; pco[0] = 1'b0; pov[0] = 1'b0;
    pa[1] = 16'hFFFF; pb[1] = 16'hFFFF; pc[1] = 1'b1; ps[1] = 16'hFFFF; pco[1] = 1'b1; pov[1] = 1'b0;
    pa[2] = 16'h4000; pb[2] = 16'h4000; pc[2] = 1'b0; ps[2] = 16'h8000; pco[2] = 1'b0; pov[2] = 1'b1;
    a16 = pa[0]; b16 = pb[0]; c16 = pc[0]; start16 = 1'b1;
    step();
    a16 = pa[1]; b16 = pb[1]; c16 = pc[1];
    k = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("b2b_hs", {rdy16, d16}, (i % 5 == 4) ? 2'b11 : 2'b00);
      if (i % 5 == 4) begin
        chk("b2b_res", {ov16, co16, s16}, {pov[k], pco[k], ps[k]});
        k++;
        if (k == 3) start16 = 1'b0;
      end
      if (i % 5 == 0 && k + 1 < 3) begin
        a16 = pa[k + 1]; b16 = pb[k + 1]; c16 = pc[k + 1];
      end
    end
    step();
    chk("b2b_idle", {rdy16, d16}, 2'b10);

    // Exhaustive 4-bit sweep on both slice widths
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int lat1, lat4, tot, sa, sb, ssum;
          logic [5:0] r1, r4;
          logic [4:0] t5;
          logic ev;
          a4 = 4'(ia); b4 = 4'(ib); c4 = 1'(ic); st4 = 1'b1;
          step();
          st4 = 1'b0;
          lat1 = 0; lat4 = 0; r1 = '0; r4 = '0;
          for (int n = 1; n <= 8; n++) begin
            step();
            if (d41 && lat1 == 0) begin lat1 = n; r1 = {ov41, co41, s41}; end
            if (d44 && lat4 == 0) begin lat4 = n; r4 = {ov44, co44, s44}; end
          end
          tot  = ia + ib + ic;
          t5   = 5'(tot);
          sa   = (ia >= 8) ? ia - 16 : ia;
          sb   = (ib >= 8) ? ib - 16 : ib;
          ssum = sa + sb + ic;
          ev   = (ssum > 7) || (ssum < -8);
          chk("sweep_s1", {8'(lat1), r1}, {8'd4, ev, t5});
          chk("sweep_s4", {8'(lat4), r4}, {8'd1, ev, t5});
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
